// File: rtl/dds_phase_acc_mc_if.sv
// Configuration write port of the multi-channel DDS phase accumulator.
// The control master drives the request fields; the accumulator returns cfg_ready.
interface dds_phase_acc_mc_if #(
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned CHANNELS  = 4
);
  localparam int unsigned CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CHAN_W-1:0]    cfg_chan;
  logic [1:0]           cfg_sel;
  logic [ACC_WIDTH-1:0] cfg_data;

  modport master (
    output cfg_valid,
    output cfg_chan,
    output cfg_sel,
    output cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_chan,
    input  cfg_sel,
    input  cfg_data,
    output cfg_ready
  );
endinterface

// File: rtl/dds_phase_acc_mc.sv
// Multi-channel DDS phase accumulator: shadowed freq/offset/sweep, coherent commit,
// per-channel clear and wrap flags. Optional LFSR phase dither under PHASE_DITHER_EN.
module dds_phase_acc_mc #(
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned FREQ_WIDTH = 16,
  parameter int unsigned OUT_WIDTH  = 12,
  parameter int unsigned CHANNELS   = 4
) (
  input  logic                          clk,
  input  logic                          res,
  input  logic                          en,
  input  logic [CHANNELS-1:0]           sync_clr,
  dds_phase_acc_mc_if.slave             cfg,
  output logic [CHANNELS*OUT_WIDTH-1:0] phase_out,
  output logic                          phase_valid,
  output logic [CHANNELS-1:0]           wrap
);
  localparam int unsigned CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned SAT_W  = FREQ_WIDTH + 2;
  localparam int unsigned TRUNC  = ACC_WIDTH - OUT_WIDTH;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_t;

  state_t state_q;
  state_t state_nx;
  logic   xfer_c;
  logic   wr_c;
  logic   commit_c;

  // Config FSM state register
  always_ff @(posedge clk) begin
    if (res) state_q <= IDLE;
    else     state_q <= state_nx;
  end

  // Config FSM next state; ready is held low during reset and in COMMIT
  always_comb begin
    state_nx      = state_q;
    cfg.cfg_ready = 1'b0;
    xfer_c        = 1'b0;
    commit_c      = 1'b0;
    case (state_q)
      IDLE: begin
        cfg.cfg_ready = !res;
        xfer_c        = cfg.cfg_valid && !res;
        if (xfer_c && (cfg.cfg_sel == 2'd3)) state_nx = COMMIT;
      end
      COMMIT: begin
        commit_c = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign wr_c = xfer_c && (cfg.cfg_sel != 2'd3);

  always_ff @(posedge clk) begin
    if (res) phase_valid <= 1'b0;
    else     phase_valid <= en;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [ACC_WIDTH-1:0]    acc_q;
    logic [ACC_WIDTH-1:0]    off_q;
    logic [ACC_WIDTH-1:0]    off_sh;
    logic [FREQ_WIDTH-1:0]   freq_q;
    logic [FREQ_WIDTH-1:0]   freq_sh;
    logic [FREQ_WIDTH-1:0]   step_q;
    logic [FREQ_WIDTH-1:0]   step_sh;
    logic [OUT_WIDTH-1:0]    phase_q;
    logic                    wrap_q;
    logic                    hit_c;
    logic [ACC_WIDTH:0]      acc_sum_c;
    logic signed [SAT_W-1:0] sweep_c;
    logic [FREQ_WIDTH-1:0]   freq_sat_c;
    logic [ACC_WIDTH-1:0]    dither_c;
    logic [ACC_WIDTH-1:0]    phase_sum_c;

    // Out-of-range channel numbers never match, so such writes are dropped
    assign hit_c     = wr_c && (cfg.cfg_chan == CHAN_W'(i));
    assign acc_sum_c = (ACC_WIDTH+1)'(acc_q) + (ACC_WIDTH+1)'(freq_q);
    assign sweep_c   = $signed({2'b00, freq_q}) + SAT_W'($signed(step_q));

    // Sweep saturates at both ends of the unsigned frequency range
    always_comb begin
      freq_sat_c = sweep_c[FREQ_WIDTH-1:0];
      if (sweep_c[SAT_W-1])      freq_sat_c = '0;
      else if (sweep_c[SAT_W-2]) freq_sat_c = '1;
    end

`ifdef PHASE_DITHER_EN
    localparam int unsigned DITH_W = (TRUNC == 0) ? 1 : ((TRUNC < 16) ? TRUNC : 16);
    logic [15:0] lfsr_q;

    // x^16+x^14+x^13+x^11+1, distinct seed per channel
    always_ff @(posedge clk) begin
      if (res)     lfsr_q <= 16'hACE1 + 16'(i);
      else if (en) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    assign dither_c = (TRUNC == 0) ? '0 : ACC_WIDTH'(lfsr_q[DITH_W-1:0]);
`else
    assign dither_c = '0;
`endif

    assign phase_sum_c = acc_q + off_q + dither_c;

    always_ff @(posedge clk) begin
      if (res) begin
        acc_q   <= '0;
        off_q   <= '0;
        off_sh  <= '0;
        freq_q  <= '0;
        freq_sh <= '0;
        step_q  <= '0;
        step_sh <= '0;
        phase_q <= '0;
        wrap_q  <= 1'b0;
      end else begin
        if (hit_c) begin
          case (cfg.cfg_sel)
            2'd0:    freq_sh <= cfg.cfg_data[FREQ_WIDTH-1:0];
            2'd1:    off_sh  <= cfg.cfg_data;
            2'd2:    step_sh <= cfg.cfg_data[FREQ_WIDTH-1:0];
            default: ;
          endcase
        end

        // Commit overrides any sweep update in the same cycle
        if (commit_c) begin
          freq_q <= freq_sh;
          off_q  <= off_sh;
          step_q <= step_sh;
        end else if (en && (|step_q)) begin
          freq_q <= freq_sat_c;
        end

        if (sync_clr[i]) begin
          acc_q  <= '0;
          wrap_q <= 1'b0;
        end else if (en) begin
          acc_q  <= acc_sum_c[ACC_WIDTH-1:0];
          wrap_q <= acc_sum_c[ACC_WIDTH];
        end else begin
          wrap_q <= 1'b0;
        end

        if (en) phase_q <= OUT_WIDTH'(phase_sum_c >> TRUNC);
      end
    end

    assign phase_out[i*OUT_WIDTH +: OUT_WIDTH] = phase_q;
    assign wrap[i]                             = wrap_q;
  end
endmodule

// File: tb/tb_dds_phase_acc_mc.sv
// Directed + randomized bench for dds_phase_acc_mc against a cycle-level arithmetic model.
module tb_dds_phase_acc_mc;
  localparam int unsigned ACC_WIDTH  = 32;
  localparam int unsigned FREQ_WIDTH = 16;
  localparam int unsigned OUT_WIDTH  = 12;
  localparam int unsigned CHANNELS   = 4;
  localparam int unsigned CHAN_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam longint      TWO_ACC    = 64'sd1 << ACC_WIDTH;
  localparam longint      FREQ_MAX   = (64'sd1 << FREQ_WIDTH) - 1;

  logic                          clk = 1'b0;
  logic                          res;
  logic                          en;
  logic [CHANNELS-1:0]           sync_clr;
  logic [CHANNELS*OUT_WIDTH-1:0] phase_out;
  logic                          phase_valid;
  logic [CHANNELS-1:0]           wrap;

  dds_phase_acc_mc_if #(.ACC_WIDTH(ACC_WIDTH), .CHANNELS(CHANNELS)) cfg_if ();

  dds_phase_acc_mc #(
    .ACC_WIDTH (ACC_WIDTH),
    .FREQ_WIDTH(FREQ_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .CHANNELS  (CHANNELS)
  ) dut (
    .clk        (clk),
    .res        (res),
    .en         (en),
    .sync_clr   (sync_clr),
    .cfg        (cfg_if),
    .phase_out  (phase_out),
    .phase_valid(phase_valid),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  // Reference state, plain integers
  longint m_acc    [CHANNELS];
  longint m_off    [CHANNELS];
  longint m_off_sh [CHANNELS];
  longint m_freq   [CHANNELS];
  longint m_freq_sh[CHANNELS];
  longint m_step   [CHANNELS];
  longint m_step_sh[CHANNELS];
  longint m_phase  [CHANNELS];
  bit     m_wrap   [CHANNELS];
  int     m_lfsr   [CHANNELS];
  bit     m_pv;
  bit     m_commit;

  int    n_cmp = 0;
  int    n_err = 0;
  string step_tag = "init";

  task automatic model_edge();
    bit        xfer;
    longint    sum;
    longint    dith;
    longint    f;
    logic [15:0] s16;
    if (res) begin
      for (int c = 0; c < CHANNELS; c++) begin
        m_acc[c] = 0; m_off[c] = 0; m_off_sh[c] = 0; m_freq[c] = 0; m_freq_sh[c] = 0;
        m_step[c] = 0; m_step_sh[c] = 0; m_phase[c] = 0; m_wrap[c] = 0;
        m_lfsr[c] = (32'hACE1 + c) & 32'hFFFF;
      end
      m_pv = 0;
      m_commit = 0;
      return;
    end
    xfer = cfg_if.cfg_valid && !m_commit;
    for (int c = 0; c < CHANNELS; c++) begin
      dith = 0;
`ifdef PHASE_DITHER_EN
      if (OUT_WIDTH < ACC_WIDTH)
        dith = m_lfsr[c] % (64'sd1 << (((ACC_WIDTH - OUT_WIDTH) < 16) ? (ACC_WIDTH - OUT_WIDTH) : 16));
`endif
      if (en) m_phase[c] = ((m_acc[c] + m_off[c] + dith) % TWO_ACC) >> (ACC_WIDTH - OUT_WIDTH);
      sum = m_acc[c] + m_freq[c];
      if (sync_clr[c]) begin
        m_acc[c] = 0; m_wrap[c] = 0;
      end else if (en) begin
        m_wrap[c] = (sum >= TWO_ACC);
        m_acc[c]  = sum % TWO_ACC;
      end else begin
        m_wrap[c] = 0;
      end
      if (m_commit) begin
        m_freq[c] = m_freq_sh[c]; m_off[c] = m_off_sh[c]; m_step[c] = m_step_sh[c];
      end else if (en && m_step[c] != 0) begin
        f = m_freq[c] + m_step[c];
        m_freq[c] = (f < 0) ? 0 : ((f > FREQ_MAX) ? FREQ_MAX : f);
      end
      if (en) m_lfsr[c] = ((m_lfsr[c] << 1) & 32'hFFFF) |
                          (((m_lfsr[c] >> 15) ^ (m_lfsr[c] >> 13) ^ (m_lfsr[c] >> 12) ^ (m_lfsr[c] >> 10)) & 1);
      if (xfer && cfg_if.cfg_sel != 2'd3 && int'(cfg_if.cfg_chan) == c) begin
        case (cfg_if.cfg_sel)
          2'd0: m_freq_sh[c] = longint'(cfg_if.cfg_data) % (FREQ_MAX + 1);
          2'd1: m_off_sh[c]  = longint'(cfg_if.cfg_data);
          default: begin
            s16 = cfg_if.cfg_data[15:0];
            m_step_sh[c] = longint'($signed(s16));
          end
        endcase
      end
    end
    m_pv     = en;
    m_commit = xfer && (cfg_if.cfg_sel == 2'd3);
  endtask

  task automatic check_outputs();
    logic [CHANNELS*OUT_WIDTH-1:0] exp_phase;
    logic [CHANNELS-1:0]           exp_wrap;
    logic                          exp_ready;
    for (int c = 0; c < CHANNELS; c++) begin
      exp_phase[c*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(m_phase[c]);
      exp_wrap[c] = m_wrap[c];
    end
    exp_ready = !m_commit && !res;
    n_cmp++;
    assert (phase_out === exp_phase) else begin
      n_err++; $error("FAIL %s phase_out observed=%h expected=%h", step_tag, phase_out, exp_phase);
    end
    n_cmp++;
    assert (wrap === exp_wrap) else begin
      n_err++; $error("FAIL %s wrap observed=%b expected=%b", step_tag, wrap, exp_wrap);
    end
    n_cmp++;
    assert (phase_valid === m_pv) else begin
      n_err++; $error("FAIL %s phase_valid observed=%b expected=%b", step_tag, phase_valid, m_pv);
    end
    n_cmp++;
    assert (cfg_if.cfg_ready === exp_ready) else begin
      n_err++; $error("FAIL %s cfg_ready observed=%b expected=%b", step_tag, cfg_if.cfg_ready, exp_ready);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic cfg_write(input logic [1:0] sel, input int chan, input logic [31:0] data);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_sel   = sel;
    cfg_if.cfg_chan  = CHAN_W'(chan);
    cfg_if.cfg_data  = data;
    cyc();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic commit();
    cfg_write(2'd3, 0, $urandom);
    cyc();
  endtask

  int obs_wraps;
  int exp_wraps;

  initial begin
    res = 1'b1; en = 1'b0; sync_clr = '0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_sel = 2'd0; cfg_if.cfg_chan = '0; cfg_if.cfg_data = '0;

    step_tag = "reset";
    cyc(); cyc();
    res = 1'b0;
    step_tag = "post_reset";
    cyc();
    n_cmp++;
    assert (cfg_if.cfg_ready === 1'b1) else begin
      n_err++; $error("FAIL ready_after_reset observed=%b expected=1", cfg_if.cfg_ready);
    end

    step_tag = "setup";
    cfg_write(2'd0, 0, 32'h0000_1000);
    cfg_write(2'd0, 1, 32'h0000_0000);
    cfg_write(2'd1, 1, 32'h8000_0000);
    cfg_write(2'd0, 2, 32'h0000_FFF0);
    cfg_write(2'd2, 2, 32'h0000_0008);
    cfg_write(2'd0, 3, 32'h0000_FFFF);
    cfg_write(2'd1, 3, $urandom);

    // Commit with valid held: a freq write in the COMMIT cycle must wait one cycle
    step_tag = "handshake";
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_sel = 2'd3; cfg_if.cfg_data = $urandom;
    cyc();
    cfg_if.cfg_sel = 2'd0; cfg_if.cfg_chan = CHAN_W'(0); cfg_if.cfg_data = 32'h0000_2222;
    n_cmp++;
    assert (cfg_if.cfg_ready === 1'b0) else begin
      n_err++; $error("FAIL ready_in_commit observed=%b expected=0", cfg_if.cfg_ready);
    end
    cyc();
    n_cmp++;
    assert (cfg_if.cfg_ready === 1'b1) else begin
      n_err++; $error("FAIL ready_after_commit observed=%b expected=1", cfg_if.cfg_ready);
    end
    cyc();
    cfg_if.cfg_valid = 1'b0;

    step_tag = "run_offset_sweep";
    en = 1'b1;
    for (int k = 0; k < 20; k++) cyc();
    n_cmp++;
    assert (phase_out[1*OUT_WIDTH +: OUT_WIDTH] === 12'h800) else begin
      n_err++; $error("FAIL offset_ch1 observed=%h expected=800", phase_out[1*OUT_WIDTH +: OUT_WIDTH]);
    end

    step_tag = "sweep_down";
    cfg_write(2'd0, 2, 32'h0000_0004);
    cfg_write(2'd2, 2, 32'h0000_FFF8);
    commit();
    for (int k = 0; k < 10; k++) cyc();

    step_tag = "random";
    for (int k = 0; k < 400; k++) begin
      en               = ($urandom_range(3) != 0);
      sync_clr         = ($urandom_range(7) == 0) ? CHANNELS'($urandom) : '0;
      cfg_if.cfg_valid = $urandom_range(1) == 1;
      cfg_if.cfg_sel   = ($urandom_range(7) == 0) ? 2'd3 : 2'($urandom_range(2));
      cfg_if.cfg_chan  = CHAN_W'($urandom);
      cfg_if.cfg_data  = $urandom;
      cyc();
    end
    sync_clr = '0; cfg_if.cfg_valid = 1'b0;
    cyc();

    step_tag = "clear_vs_acc";
    cfg_write(2'd0, 0, 32'h0000_1000);
    cfg_write(2'd2, 0, 32'h0000_0000);
    commit();
    en = 1'b1;
    for (int k = 0; k < 5; k++) cyc();
    sync_clr = 4'b0001;
    cyc();
    sync_clr = '0;
    n_cmp++;
    assert (wrap[0] === 1'b0) else begin
      n_err++; $error("FAIL clear_wrap0 observed=%b expected=0", wrap[0]);
    end
    cyc();

    step_tag = "long_wrap";
    cfg_write(2'd0, 3, 32'h0000_FFFF);
    cfg_write(2'd2, 3, 32'h0000_0000);
    commit();
    obs_wraps = 0; exp_wraps = 0;
    for (int k = 0; k < 66000; k++) begin
      cyc();
      obs_wraps += int'(wrap[3]);
      exp_wraps += int'(m_wrap[3]);
    end
    n_cmp++;
    assert (obs_wraps === exp_wraps && exp_wraps > 0) else begin
      n_err++; $error("FAIL wrap3_count observed=%0d expected=%0d", obs_wraps, exp_wraps);
    end

    // Reset during COMMIT discards the commit
    step_tag = "reset_in_commit";
    cfg_write(2'd3, 0, $urandom);
    res = 1'b1;
    cyc();
    res = 1'b0; en = 1'b0;
    n_cmp++;
    assert (phase_out === '0 && wrap === '0 && phase_valid === 1'b0) else begin
      n_err++; $error("FAIL reset_in_commit observed=%h/%b/%b expected=0/0/0", phase_out, wrap, phase_valid);
    end
    cyc();
    en = 1'b1;
    for (int k = 0; k < 8; k++) cyc();
    n_cmp++;
    assert (phase_out === '0) else begin
      n_err++; $error("FAIL after_reset_phase observed=%h expected=0", phase_out);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dds_phase_acc_mc.md
Name: dds_phase_acc_mc

Overview:
- Multi-channel DDS phase accumulator for the DDS datapath. Successor to the single-channel accumulator, generalised in width and channel count.
- Adds per-channel phase offset, linear frequency sweep, phase-coherent shadow-register commit, synchronous channel clear, wrap flags and truncated phase output.
- Feeds the phase-to-amplitude LUT stage; configured by a control master over a valid/ready write port.

Parameters:
- ACC_WIDTH, 32: accumulator width; also width of phase offset and cfg_data.
- FREQ_WIDTH, 16: frequency word width. FREQ_WIDTH <= ACC_WIDTH.
- OUT_WIDTH, 12: truncated phase output width per channel. OUT_WIDTH <= ACC_WIDTH.
- CHANNELS, 4: number of independent channels, >= 1.

Ports:
- clk  in  1  clock.
- res  in  1  synchronous active-high reset.
- en  in  1  accumulate/sweep enable for all channels.
- sync_clr  in  CHANNELS  per-channel accumulator clear.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config port can accept.
- cfg_chan  in  max(1,$clog2(CHANNELS))  target channel.
- cfg_sel  in  2  0=freq shadow, 1=offset shadow, 2=sweep step shadow, 3=commit.
- cfg_data  in  ACC_WIDTH  write data; low bits used as the field width requires.
- phase_out  out  CHANNELS*OUT_WIDTH  truncated phase; channel i at bits [i*OUT_WIDTH +: OUT_WIDTH].
- phase_valid  out  1  phase_out updated this cycle.
- wrap  out  CHANNELS  one-cycle pulse on accumulator carry-out.

Behaviour:
- Reset (res=1 at clk edge): all accumulators, active and shadow freq/offset/step registers, phase_out, phase_valid and wrap go to 0. cfg_ready=0 while res=1 and 1 on the first cycle after.
- Config FSM, states IDLE and COMMIT:
  - In IDLE, cfg_ready=1. A transfer occurs when cfg_valid && cfg_ready.
  - cfg_sel 0/1/2 writes the shadow register of channel cfg_chan and stays in IDLE.
  - cfg_sel 3 moves to COMMIT; cfg_chan is ignored.
  - In COMMIT, cfg_ready=0. All channels copy shadow to active at the end of that cycle, then return to IDLE.
  - New freq/offset/step values are first used by the accumulator in the cycle after COMMIT.
- cfg_chan >= CHANNELS: the write is accepted and discarded.
- Field widths:
  - Freq and step take cfg_data[FREQ_WIDTH-1:0]; step is two's-complement signed.
  - Offset takes the full ACC_WIDTH.
- Accumulator, per channel, when en=1:
  - acc <= acc + zero_extend(freq_active), mod 2^ACC_WIDTH.
  - wrap[i] is registered high for one cycle when that addition carries out.
- Sweep, per channel, when en=1 and step!=0:
  - freq_active <= freq_active + step, saturating to [0, 2^FREQ_WIDTH-1] with no wrap.
  - The accumulator uses the pre-update freq_active in that cycle.
  - A COMMIT in the same cycle overrides the sweep result.
- Output:
  - phase_out[i] <= top OUT_WIDTH bits of (acc_i + offset_active_i), mod 2^ACC_WIDTH, registered every cycle en=1. Latency is 1 cycle from the acc value.
  - phase_valid <= en.
  - When en=0, accumulators, freq and phase_out hold, and wrap=0.
- sync_clr[i]=1: acc_i <= 0 regardless of en, wrap[i] <= 0. Clear has priority over accumulate. freq, offset and step are unaffected.
- Simultaneous sync_clr and COMMIT: both take effect.
- res asserted mid-COMMIT: reset wins; the commit is lost.

Optional Feature:
- Macro PHASE_DITHER_EN.
- Defined:
  - A 16-bit maximal-length LFSR per channel (x^16+x^14+x^13+x^11+1) is seeded to 16'hACE1 + i on reset and advances each en cycle.
  - Its low (ACC_WIDTH-OUT_WIDTH) bits, or all 16 if fewer, are added below the truncation point before truncation.
  - Not applied when OUT_WIDTH == ACC_WIDTH.
- Undefined: no LFSR logic; plain truncation exactly as in Behaviour.

Test Plan:
- Reset then idle: res=1 for 2 cycles, en=0 -> all outputs 0; cfg_ready=1 one cycle after res drops.
- Freq commit, CHANNELS=4, ACC=32, OUT=12: write freq ch0=16'h1000, commit, en=1 -> wrap[0] pulses every 2^20 cycles; phase_out ch0 steps by 1 every 256 cycles. Other channels stay 0.
- Offset: ch1 freq=0, offset=32'h8000_0000, commit, en=1 -> phase_out ch1 = 12'h800 constant; wrap[1] never pulses.
- Sweep saturation: ch2 freq=16'hFFF0, step=16'h0008, commit, en=1 -> freq_active 16'hFFF8, then 16'hFFFF and held. Step 16'hFFF8 (-8) from freq 16'h0004 -> 0 and held.
- Handshake: cfg_valid held high with commit -> cfg_ready low exactly 1 cycle. A freq write presented in COMMIT is accepted only in the next cycle, and no value changes before commit.
- Clear vs accumulate: en=1, sync_clr[0]=1 for one cycle with freq=16'h1000 -> acc0=0 the next cycle, wrap[0]=0. Next cycle, with res asserted during a COMMIT cycle -> all active registers 0.
